// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the 4-digit multiplexed 7-segment scan driver:
// active-low segment patterns {g,f,e,d,c,b,a}, scan phase encoding,
// digit count and the tens/units split helpers.
package seg7_scan_driver_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    PH_DEAD = 1'b0,
    PH_ON   = 1'b1
  } phase_e;

  // Values 60..63 intentionally give tens=6 (no clamping).
  function automatic logic [3:0] tens_of(input logic [5:0] n);
    return 4'(n / 6'd10);
  endfunction

  function automatic logic [3:0] units_of(input logic [5:0] n);
    return 4'(n % 6'd10);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Timer-to-display bundle: pair values and dot in, display pins out.
// The blink request exists only when DISPLAY_BLINK_EN is defined.
interface seg7_scan_driver_if;

  logic [5:0] led_num0;
  logic [5:0] led_num1;
  logic       led_dot;
`ifdef DISPLAY_BLINK_EN
  logic       blink;
`endif
  logic [6:0] seg_n;
  logic       dp_n;
  logic [seg7_scan_driver_pkg::NUM_DIGITS-1:0] digit_en_n;

`ifdef DISPLAY_BLINK_EN
  modport master (output led_num0, led_num1, led_dot, blink,
                  input  seg_n, dp_n, digit_en_n);
  modport slave  (input  led_num0, led_num1, led_dot, blink,
                  output seg_n, dp_n, digit_en_n);
`else
  modport master (output led_num0, led_num1, led_dot,
                  input  seg_n, dp_n, digit_en_n);
  modport slave  (input  led_num0, led_num1, led_dot,
                  output seg_n, dp_n, digit_en_n);
`endif

endinterface

// File: rtl/seg7_scan_driver_decode.sv
// BCD digit to active-low 7-segment pattern; codes 10..15 are blanked.
module seg7_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_n_o
);

  // Pure lookup, blank for anything that is not a decimal digit.
  always_comb begin
    seg_n_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_n_o = SEG_0;
      4'd1:    seg_n_o = SEG_1;
      4'd2:    seg_n_o = SEG_2;
      4'd3:    seg_n_o = SEG_3;
      4'd4:    seg_n_o = SEG_4;
      4'd5:    seg_n_o = SEG_5;
      4'd6:    seg_n_o = SEG_6;
      4'd7:    seg_n_o = SEG_7;
      4'd8:    seg_n_o = SEG_8;
      4'd9:    seg_n_o = SEG_9;
      default: seg_n_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode multiplexed display driver for the stopwatch.
// Each digit slot is DEAD_CYCLES all-off cycles followed by an ON window;
// inputs are snapshotted once per frame so a digit never tears mid-scan.
// Optional feature macro: DISPLAY_BLINK_EN (adds blink port and blink timer).
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV    = 500,
  parameter int DEAD_CYCLES = 8,
  parameter int BLINK_DIV   = 250000
)
(
  input  logic              clock,
  input  logic              reset_n,
  seg7_scan_driver_if.slave bus
);

  if (DEAD_CYCLES < 1 || DEAD_CYCLES >= SCAN_DIV || BLINK_DIV < 1) begin : g_bad_cfg
    $error("seg7_scan_driver: need 1 <= DEAD_CYCLES < SCAN_DIV and BLINK_DIV >= 1");
  end

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  phase_e                phase_q, phase_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wrap;
  logic                  first_q;
  logic [5:0]            num0_q, num1_q;
  logic                  dot_q;
  logic [3:0]            digit_bcd;
  logic [6:0]            digit_seg;
  logic                  blank_on;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;

  // Scan state register: phase, digit index and slot counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_DEAD;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Slot sequencing: DEAD for DEAD_CYCLES, then ON until the slot ends.
  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    case (phase_q)
      PH_DEAD: begin
        if (cnt_q == DEAD_LAST) phase_d = PH_ON;
      end
      PH_ON: begin
        if (cnt_q == CNT_LAST) begin
          phase_d = PH_DEAD;
          idx_d   = idx_q + IDX_W'(1);
          wrap    = (idx_q == IDX_LAST);
        end
      end
      default: phase_d = PH_DEAD;
    endcase
  end

  // Frame snapshot: taken right after reset release and at every 3->0 wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      first_q <= 1'b1;
      num0_q  <= '0;
      num1_q  <= '0;
      dot_q   <= 1'b0;
    end else begin
      first_q <= 1'b0;
      if (first_q || wrap) begin
        num0_q <= bus.led_num0;
        num1_q <= bus.led_num1;
        dot_q  <= bus.led_dot;
      end
    end
  end

  // Pick the BCD digit belonging to the currently scanned position.
  always_comb begin
    digit_bcd = 4'd0;
    case (idx_q)
      2'd0:    digit_bcd = tens_of(num0_q);
      2'd1:    digit_bcd = units_of(num0_q);
      2'd2:    digit_bcd = tens_of(num1_q);
      default: digit_bcd = units_of(num1_q);
    endcase
  end

  seg7_decode u_decode (
    .bcd_i   (digit_bcd),
    .seg_n_o (digit_seg)
  );

`ifdef DISPLAY_BLINK_EN
  localparam int BLK_W = $clog2(BLINK_DIV + 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] blink_cnt_q;
  logic             blink_state_q;

  // Free-running blink timer; the state flips every BLINK_DIV cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q   <= '0;
      blink_state_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q   <= '0;
      blink_state_q <= ~blink_state_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + BLK_W'(1);
    end
  end

  assign blank_on = bus.blink & blink_state_q;
`else
  assign blank_on = 1'b0;
`endif

  // Pin values for the current state; blanking never stops the digit scan.
  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    en_d  = '1;
    if (phase_q == PH_ON) begin
      en_d = ~(NUM_DIGITS'(1) << idx_q);
      if (!blank_on) begin
        seg_d = digit_seg;
        dp_d  = ~((idx_q == IDX_W'(1)) && dot_q);
      end
    end
  end

  // Registered pins: one cycle behind the scan state, all off in reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
      en_q  <= '1;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      en_q  <= en_d;
    end
  end

  assign bus.seg_n      = seg_q;
  assign bus.dp_n       = dp_q;
  assign bus.digit_en_n = en_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=20, DEAD_CYCLES=4,
// BLINK_DIV=200 (frame = 80 cycles). Blink checks only with DISPLAY_BLINK_EN.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV    = 20;
  localparam int DEAD_CYCLES = 4;
  localparam int BLINK_DIV   = 200;
  localparam int FRAME       = 4 * SCAN_DIV;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00, S9 = 7'h10;
  localparam logic [6:0] BLK = 7'h7F;

  typedef struct {
    logic [5:0]      n0;
    logic [5:0]      n1;
    logic            dot;
    logic [3:0][6:0] seg;   // {d3,d2,d1,d0}
  } vec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   k = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic blink_tb = 1'b0;

  always #5 clock = ~clock;

  seg7_scan_driver_if bus();

  seg7_scan_driver #(
    .SCAN_DIV    (SCAN_DIV),
    .DEAD_CYCLES (DEAD_CYCLES),
    .BLINK_DIV   (BLINK_DIV)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at k=%0d: got {en,seg,dp}=%h expected %h", name, k, act, exp);
    end
  endtask

  task automatic apply(input vec_t r);
    bus.led_num0 = r.n0;
    bus.led_num1 = r.n1;
    bus.led_dot  = r.dot;
  endtask

  // Advance one clock and compare pins against the expected scan position.
  task automatic step_check(input vec_t r, input string name);
    logic [11:0] exp;
    logic        blank;
    int          pos, slot;
    @(posedge clock);
    k++;
    @(negedge clock);
    pos   = (k - 1) % SCAN_DIV;
    slot  = ((k - 1) / SCAN_DIV) % 4;
    blank = 1'b0;
`ifdef DISPLAY_BLINK_EN
    blank = blink_tb && ((((k - 1) / BLINK_DIV) % 2) == 1);
`endif
    if (pos < DEAD_CYCLES)
      exp = {4'hF, BLK, 1'b1};
    else if (blank)
      exp = {~(4'b0001 << slot), BLK, 1'b1};
    else
      exp = {~(4'b0001 << slot), r.seg[slot], ((slot == 1) && r.dot) ? 1'b0 : 1'b1};
    check(name, {bus.digit_en_n, bus.seg_n, bus.dp_n}, exp);
  endtask

  task automatic run(input vec_t r, input string name, input int n);
    for (int i = 0; i < n; i++) step_check(r, name);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t r_zero, r_prev, r_rst, r59, r60;

    r_zero  = '{6'd0,  6'd0,  1'b0, {S0, S0, S0, S0}};
    vecs[0] = '{6'd12, 6'd34, 1'b1, {S4, S3, S2, S1}};
    vecs[1] = '{6'd63, 6'd0,  1'b0, {S0, S0, S3, S6}};
    vecs[2] = '{6'd5,  6'd59, 1'b1, {S9, S5, S5, S0}};
    vecs[3] = '{6'd60, 6'd47, 1'b0, {S7, S4, S0, S6}};
    vecs[4] = '{6'd28, 6'd16, 1'b1, {S6, S1, S8, S2}};
    r_rst   = '{6'd21, 6'd9,  1'b0, {S9, S0, S1, S2}};
    r59     = '{6'd59, 6'd7,  1'b0, {S7, S0, S9, S5}};
    r60     = '{6'd60, 6'd7,  1'b0, {S7, S0, S0, S6}};

    apply(r_zero);
`ifdef DISPLAY_BLINK_EN
    bus.blink = 1'b0;
`endif
    #12;
    check("reset_state", {bus.digit_en_n, bus.seg_n, bus.dp_n}, {4'hF, BLK, 1'b1});
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    k = 0;

    run(r_zero, "frame0_zero", FRAME);

    r_prev = r_zero;
    for (int v = 0; v < 5; v++) begin
      apply(vecs[v]);
      run(r_prev, "held_prev", FRAME);
      run(vecs[v], "table_vec", FRAME);
      r_prev = vecs[v];
    end

    // Reset in the middle of the d2 ON window.
    run(r_prev, "pre_reset", 50);
    check("d2_lit_before_reset", {bus.digit_en_n, bus.seg_n, bus.dp_n},
          {4'b1011, S1, 1'b1});
    #2 reset_n = 1'b0;
    #1 check("async_reset_off", {bus.digit_en_n, bus.seg_n, bus.dp_n}, {4'hF, BLK, 1'b1});
    apply(r_rst);
    @(posedge clock);
    @(negedge clock);
    check("reset_held_off", {bus.digit_en_n, bus.seg_n, bus.dp_n}, {4'hF, BLK, 1'b1});
    reset_n = 1'b1;
    k = 0;
    run(r_rst, "after_reset", FRAME);

    // 59 -> 60 applied in the d2 slot: invisible until the next frame.
    apply(r59);
    run(r_rst, "held_rst", FRAME);
    run(r59, "show59", 45);
    apply(r60);
    run(r59, "midframe_hold", FRAME - 45);
    run(r60, "show60", FRAME);

`ifdef DISPLAY_BLINK_EN
    bus.blink = 1'b1;
    blink_tb  = 1'b1;
    run(r60, "blink_on", 2 * BLINK_DIV);
    bus.blink = 1'b0;
    blink_tb  = 1'b0;
    run(r60, "blink_off", FRAME);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, k=%0d", k);
    $fatal(1, "watchdog");
  end

endmodule
